// File: rtl/k12a_mem_arbiter_pkg.sv
// Shared types and widths for the K12A memory-port arbiter.
// Optional write protection is controlled by K12A_MEM_ARB_PROTECT_EN.
package k12a_mem_arbiter_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COUNT_W = 8;

    typedef enum logic [2:0] {
        ARB_STATE_CPU,
        ARB_STATE_DRAIN,
        ARB_STATE_EXT,
        ARB_STATE_ACK,
        ARB_STATE_RELEASE
    } arb_state_t;

    // Only the grant state routes the external requester onto the memory port.
    function automatic logic arb_selects_ext(arb_state_t state);
        return state == ARB_STATE_EXT;
    endfunction

endpackage

// File: rtl/k12a_mem_arbiter_if.sv
// Bus bundle between core, external requester, arbiter and memory macro.
// ext_err exists only when K12A_MEM_ARB_PROTECT_EN is defined.
interface k12a_mem_arbiter_if;
    import k12a_mem_arbiter_pkg::*;

    logic              cpu_mem_enable;
    logic              cpu_mem_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_boundary;
    logic              cpu_hold;

    logic              ext_req;
    logic              ext_write;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ack;
    logic [DATA_W-1:0] ext_rdata;
`ifdef K12A_MEM_ARB_PROTECT_EN
    logic              ext_err;
`endif

    logic              mem_enable;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_mem_enable, cpu_mem_write, cpu_addr, cpu_wdata, cpu_boundary,
        output cpu_hold,
        input  ext_req, ext_write, ext_addr, ext_wdata,
        output ext_ack, ext_rdata,
`ifdef K12A_MEM_ARB_PROTECT_EN
        output ext_err,
`endif
        output mem_enable, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_mem_enable, cpu_mem_write, cpu_addr, cpu_wdata, cpu_boundary,
        input  cpu_hold,
        output ext_req, ext_write, ext_addr, ext_wdata,
        input  ext_ack, ext_rdata,
`ifdef K12A_MEM_ARB_PROTECT_EN
        input  ext_err,
`endif
        input  mem_enable, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/k12a_mem_arbiter_mux.sv
// Combinational source select for the single memory port.
module k12a_mem_arbiter_mux
    import k12a_mem_arbiter_pkg::*;
(
    input  logic              sel_ext,
    input  logic              gate_off,
    input  logic              cpu_mem_enable,
    input  logic              cpu_mem_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ext_enable,
    input  logic              ext_write,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              mem_enable,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    always_comb begin
        mem_enable = cpu_mem_enable;
        mem_write  = cpu_mem_write;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        if (sel_ext) begin
            mem_enable = ext_enable;
            mem_write  = ext_write;
            mem_addr   = ext_addr;
            mem_wdata  = ext_wdata;
        end
        if (gate_off) begin
            mem_enable = 1'b0;
        end
    end

endmodule

// File: rtl/k12a_mem_arbiter.sv
// Arbiter sharing the K12A memory port between the core and an external requester.
// Define K12A_MEM_ARB_PROTECT_EN to block external writes at or above PROTECT_BASE.
module k12a_mem_arbiter
    import k12a_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8
`ifdef K12A_MEM_ARB_PROTECT_EN
    ,
    parameter logic [ADDR_W-1:0] PROTECT_BASE = 16'hF000
`endif
) (
    input logic               clock,
    input logic               reset_n,
    k12a_mem_arbiter_if.slave bus
);

    localparam logic [COUNT_W-1:0] BURST_LIMIT = COUNT_W'(MAX_BURST);

    arb_state_t         state_q;
    logic [COUNT_W-1:0] burst_q;
    logic               ext_ack_q;
    logic [DATA_W-1:0]  ext_rdata_q;
    logic               ext_blocked;
    logic               ext_enable;
    logic               gate_off;

`ifdef K12A_MEM_ARB_PROTECT_EN
    logic ext_err_q;

    assign ext_blocked = bus.ext_write && (bus.ext_addr >= PROTECT_BASE);
    assign bus.ext_err = ext_err_q;
`else
    assign ext_blocked = 1'b0;
`endif

    assign ext_enable = bus.ext_req && !ext_blocked;
    // Memory stays quiet in reset and in the ack turnaround cycle.
    assign gate_off   = !reset_n || (state_q == ARB_STATE_ACK);

    // Hold starts combinationally at the boundary so the core freezes on that edge.
    assign bus.cpu_hold = ((state_q == ARB_STATE_DRAIN) && bus.cpu_boundary) ||
                          (state_q == ARB_STATE_EXT) || (state_q == ARB_STATE_ACK);
    assign bus.ext_ack   = ext_ack_q;
    assign bus.ext_rdata = ext_rdata_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_STATE_CPU;
            burst_q     <= '0;
            ext_ack_q   <= 1'b0;
            ext_rdata_q <= '0;
`ifdef K12A_MEM_ARB_PROTECT_EN
            ext_err_q   <= 1'b0;
`endif
        end else begin
            ext_ack_q <= 1'b0;
`ifdef K12A_MEM_ARB_PROTECT_EN
            ext_err_q <= 1'b0;
`endif
            case (state_q)
                ARB_STATE_CPU: begin
                    if (bus.ext_req) state_q <= ARB_STATE_DRAIN;
                end
                ARB_STATE_DRAIN: begin
                    if (bus.cpu_boundary) state_q <= ARB_STATE_EXT;
                    else if (!bus.ext_req) state_q <= ARB_STATE_CPU;
                end
                ARB_STATE_EXT: begin
                    if (bus.ext_req) begin
                        ext_ack_q   <= 1'b1;
                        ext_rdata_q <= bus.ext_write ? '0 : bus.mem_rdata;
`ifdef K12A_MEM_ARB_PROTECT_EN
                        ext_err_q   <= ext_blocked;
`endif
                        if (burst_q < BURST_LIMIT) burst_q <= burst_q + 1'b1;
                        state_q <= ARB_STATE_ACK;
                    end else begin
                        state_q <= ARB_STATE_RELEASE;
                    end
                end
                ARB_STATE_ACK: begin
                    if (bus.ext_req && (burst_q < BURST_LIMIT)) state_q <= ARB_STATE_EXT;
                    else state_q <= ARB_STATE_RELEASE;
                end
                ARB_STATE_RELEASE: begin
                    burst_q <= '0;
                    state_q <= ARB_STATE_CPU;
                end
                default: state_q <= ARB_STATE_CPU;
            endcase
        end
    end

    k12a_mem_arbiter_mux u_mux (
        .sel_ext        (arb_selects_ext(state_q)),
        .gate_off       (gate_off),
        .cpu_mem_enable (bus.cpu_mem_enable),
        .cpu_mem_write  (bus.cpu_mem_write),
        .cpu_addr       (bus.cpu_addr),
        .cpu_wdata      (bus.cpu_wdata),
        .ext_enable     (ext_enable),
        .ext_write      (bus.ext_write),
        .ext_addr       (bus.ext_addr),
        .ext_wdata      (bus.ext_wdata),
        .mem_enable     (bus.mem_enable),
        .mem_write      (bus.mem_write),
        .mem_addr       (bus.mem_addr),
        .mem_wdata      (bus.mem_wdata)
    );

endmodule

// File: tb/tb_k12a_mem_arbiter.sv
// Self-checking bench for k12a_mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model with a shadow memory.
module tb_k12a_mem_arbiter;

    localparam int unsigned TB_MAX = 8;

    typedef enum {M_CPU, M_WAIT, M_GRANT, M_ACK, M_GIVEBACK} mode_t;

    logic clock;
    logic reset_n;
    k12a_mem_arbiter_if bus ();

    logic [7:0] tb_mem [0:65535] = '{default: 8'h00};
    logic [7:0] shadow [0:65535] = '{default: 8'h00};

    mode_t      m_mode;
    int         m_burst;
    logic       m_ack;
    logic [7:0] m_rdata;
    logic       m_err;

    int n_cmp;
    int n_fail;

    k12a_mem_arbiter #(.MAX_BURST(TB_MAX)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    always @(posedge clock) begin
        if (bus.mem_enable && bus.mem_write) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end

    function automatic logic prot_blocked(logic w, logic [15:0] a);
        logic b;
        b = 1'b0;
`ifdef K12A_MEM_ARB_PROTECT_EN
        b = w && (a >= 16'hF000);
`endif
        return b;
    endfunction

    // Transaction-level model: who owns the port, how many accesses this grant.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_mode  = M_CPU;
            m_burst = 0;
            m_ack   = 1'b0;
            m_rdata = 8'h00;
            m_err   = 1'b0;
        end else begin
            m_ack = 1'b0;
            m_err = 1'b0;
            if ((m_mode == M_CPU || m_mode == M_WAIT || m_mode == M_GIVEBACK) &&
                bus.cpu_mem_enable && bus.cpu_mem_write)
                shadow[bus.cpu_addr] = bus.cpu_wdata;
            case (m_mode)
                M_CPU:  if (bus.ext_req) m_mode = M_WAIT;
                M_WAIT: begin
                    if (bus.cpu_boundary) m_mode = M_GRANT;
                    else if (!bus.ext_req) m_mode = M_CPU;
                end
                M_GRANT: begin
                    if (bus.ext_req) begin
                        m_ack   = 1'b1;
                        m_rdata = bus.ext_write ? 8'h00 : shadow[bus.ext_addr];
                        m_err   = prot_blocked(bus.ext_write, bus.ext_addr);
                        if (bus.ext_write && !m_err) shadow[bus.ext_addr] = bus.ext_wdata;
                        if (m_burst < TB_MAX) m_burst = m_burst + 1;
                        m_mode = M_ACK;
                    end else begin
                        m_mode = M_GIVEBACK;
                    end
                end
                M_ACK: m_mode = (bus.ext_req && m_burst < TB_MAX) ? M_GRANT : M_GIVEBACK;
                default: begin
                    m_burst = 0;
                    m_mode  = M_CPU;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic exp_hold, exp_en, sel_ext;
        logic [31:0] exp_bus, act_bus;
        exp_hold = 1'b0;
        exp_en   = 1'b0;
        sel_ext  = 1'b0;
        if (reset_n) begin
            exp_hold = (m_mode == M_WAIT && bus.cpu_boundary) || m_mode == M_GRANT ||
                       m_mode == M_ACK;
            sel_ext  = (m_mode == M_GRANT);
            if (sel_ext) exp_en = bus.ext_req && !prot_blocked(bus.ext_write, bus.ext_addr);
            else if (m_mode != M_ACK) exp_en = bus.cpu_mem_enable;
        end
        check("cpu_hold", 32'(bus.cpu_hold), 32'(exp_hold));
        check("mem_enable", 32'(bus.mem_enable), 32'(exp_en));
        if (exp_en) begin
            act_bus = 32'({bus.mem_write, bus.mem_addr, bus.mem_wdata});
            exp_bus = sel_ext ? 32'({bus.ext_write, bus.ext_addr, bus.ext_wdata})
                              : 32'({bus.cpu_mem_write, bus.cpu_addr, bus.cpu_wdata});
            check("mem_bus", act_bus, exp_bus);
        end
        check("ext_ack", 32'(bus.ext_ack), 32'(reset_n && m_ack));
        if (reset_n && m_ack) check("ext_rdata", 32'(bus.ext_rdata), 32'(m_rdata));
`ifdef K12A_MEM_ARB_PROTECT_EN
        check("ext_err", 32'(bus.ext_err), 32'(reset_n && m_err));
`endif
    endtask

    task automatic settle();
        @(negedge clock);
        compare_all();
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        bus.cpu_mem_enable = 1'b0;
        bus.cpu_mem_write  = 1'b0;
        bus.cpu_addr       = 16'h0000;
        bus.cpu_wdata      = 8'h00;
        bus.cpu_boundary   = 1'b0;
        bus.ext_req        = 1'b0;
        bus.ext_write      = 1'b0;
        bus.ext_addr       = 16'h0000;
        bus.ext_wdata      = 8'h00;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_mem_enable = 1'b1;
        bus.cpu_mem_write  = 1'b1;
        bus.cpu_addr       = a;
        bus.cpu_wdata      = d;
        tick();
        bus.cpu_mem_enable = 1'b0;
        bus.cpu_mem_write  = 1'b0;
    endtask

    task automatic ext_start(input logic w, input logic [15:0] a, input logic [7:0] d);
        bus.ext_req   = 1'b1;
        bus.ext_write = w;
        bus.ext_addr  = a;
        bus.ext_wdata = d;
    endtask

    // Advances until ext_ack shows; drops the request in the ack cycle. Ends at negedge.
    task automatic run_until_ack(input int budget, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < budget) begin
            advance();
            lat++;
            if (bus.ext_ack) begin
                got = 1'b1;
                bus.ext_req = 1'b0;
            end
            settle();
        end
        if (!got) check("ack_timeout", 32'(0), 32'(1));
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 16'h0000 + 16'($urandom_range(0, 15));
            1: return 16'h1234;
            2: return 16'h0100;
            3: return 16'hEFFF;
            4: return 16'hF010;
            default: return 16'hFFFF;
        endcase
    endfunction

    initial begin
        int lat, k, acks_first;
        logic seen_release;
        n_cmp   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        idle_inputs();
        tick();
        settle();
        check("rst_hold", 32'(bus.cpu_hold), 32'(0));
        check("rst_ack", 32'(bus.ext_ack), 32'(0));
        check("rst_rdata", 32'(bus.ext_rdata), 32'(8'h00));
        check("rst_mem_en", 32'(bus.mem_enable), 32'(0));
        advance();
        reset_n = 1'b1;
        tick();

        // Read while the core is mid-instruction: hold waits for the boundary.
        cpu_write(16'h1234, 8'h5A);
        ext_start(1'b0, 16'h1234, 8'h00);
        tick();
        settle();
        check("hold_before_boundary", 32'(bus.cpu_hold), 32'(0));
        advance();
        bus.cpu_boundary = 1'b1;
        settle();
        check("hold_at_boundary", 32'(bus.cpu_hold), 32'(1));
        run_until_ack(8, lat);
        check("read_latency", 32'(lat), 32'(2));
        check("read_data", 32'(bus.ext_rdata), 32'(8'h5A));
        advance();
        bus.cpu_boundary = 1'b0;
        tick();
        tick();
        settle();
        check("hold_released", 32'(bus.cpu_hold), 32'(0));
        advance();

        // Halted core: write granted with minimum latency.
        bus.cpu_boundary = 1'b1;
        ext_start(1'b1, 16'h0100, 8'h20);
        run_until_ack(8, lat);
        check("halt_latency", 32'(lat), 32'(3));
        check("write_rdata_zero", 32'(bus.ext_rdata), 32'(8'h00));
        advance();
        tick();
        check("halt_write_mem", 32'(tb_mem[16'h0100]), 32'(8'h20));

        // Burst of ten writes is split by the burst limit.
        k = 0;
        acks_first = 0;
        seen_release = 1'b0;
        ext_start(1'b1, 16'h0000, 8'h40);
        for (int c = 0; c < 80 && k < 10; c++) begin
            advance();
            if (bus.ext_ack) begin
                k++;
                if (k < 10) ext_start(1'b1, 16'(k), 8'(8'h40 + k));
                else bus.ext_req = 1'b0;
            end
            settle();
            if (k > 0 && !seen_release && !bus.cpu_hold) begin
                seen_release = 1'b1;
                acks_first = k;
            end
        end
        check("burst_total", 32'(k), 32'(10));
        check("burst_first_grant", 32'(acks_first), 32'(TB_MAX));
        advance();
        tick();
        tick();
        check("burst_mem_first", 32'(tb_mem[16'h0000]), 32'(8'h40));
        check("burst_mem_last", 32'(tb_mem[16'h0009]), 32'(8'h49));

        // Request withdrawn before the boundary: back to the core, no hold.
        bus.cpu_boundary = 1'b0;
        ext_start(1'b0, 16'h0100, 8'h00);
        tick();
        bus.ext_req = 1'b0;
        settle();
        check("drain_no_hold", 32'(bus.cpu_hold), 32'(0));
        advance();
        bus.cpu_boundary = 1'b1;
        settle();
        check("drain_returned", 32'(bus.cpu_hold), 32'(0));
        check("drain_no_ack", 32'(bus.ext_ack), 32'(0));
        advance();
        bus.cpu_boundary = 1'b0;
        tick();

        // Reset asserted while the write is on the bus.
        cpu_write(16'h0200, 8'h11);
        bus.cpu_boundary = 1'b1;
        ext_start(1'b1, 16'h0200, 8'h99);
        tick();
        tick();
        settle();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_hold", 32'(bus.cpu_hold), 32'(0));
        check("rst_mid_ack", 32'(bus.ext_ack), 32'(0));
        check("rst_mid_mem_en", 32'(bus.mem_enable), 32'(0));
        idle_inputs();
        advance();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("rst_no_write", 32'(tb_mem[16'h0200]), 32'(8'h11));

        bus.cpu_boundary = 1'b1;
`ifdef K12A_MEM_ARB_PROTECT_EN
        ext_start(1'b1, 16'hF010, 8'hFF);
        run_until_ack(8, lat);
        check("prot_err", 32'(bus.ext_err), 32'(1));
        advance();
        tick();
        check("prot_mem", 32'(tb_mem[16'hF010]), 32'(8'h00));
        ext_start(1'b1, 16'hEFFF, 8'h33);
        run_until_ack(8, lat);
        check("unprot_err", 32'(bus.ext_err), 32'(0));
        advance();
        tick();
        check("unprot_mem", 32'(tb_mem[16'hEFFF]), 32'(8'h33));
`else
        ext_start(1'b1, 16'hF010, 8'hFF);
        run_until_ack(8, lat);
        advance();
        tick();
        check("high_write_mem", 32'(tb_mem[16'hF010]), 32'(8'hFF));
`endif
        bus.cpu_boundary = 1'b0;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.cpu_mem_enable = 1'($urandom_range(0, 1));
            bus.cpu_mem_write  = 1'($urandom_range(0, 1));
            bus.cpu_addr       = pick_addr();
            bus.cpu_wdata      = 8'($urandom);
            bus.cpu_boundary   = ($urandom_range(0, 2) == 0);
            if (!bus.ext_req) begin
                if ($urandom_range(0, 3) == 0)
                    ext_start(1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
            end else if (bus.ext_ack) begin
                if ($urandom_range(0, 1) == 0) bus.ext_req = 1'b0;
                else ext_start(1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.ext_req = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/k12a_mem_arbiter.md
Name: k12a_mem_arbiter

Overview:
Shares the single K12A memory port between the CPU core and an external requester (debug/loader port).
- CPU owns the bus by default.
- On an external request, the block holds the CPU at a safe instruction boundary, grants the bus for a bounded burst, then returns it to the CPU.
- Sits between the core FSM/datapath memory signals and the memory macro; memory read is combinational, write commits at the clock edge.

Parameters:
MAX_BURST, 8, max consecutive external accesses per grant before the CPU must get at least one instruction boundary (1..255).
PROTECT_BASE, 16'hF000, lowest address write-protected against the external port (used only with the optional feature).

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_mem_enable  in  1  CPU memory access this cycle
cpu_mem_write  in  1  1 = write, 0 = read
cpu_addr  in  16  CPU address bus
cpu_wdata  in  8  CPU data bus (write data)
cpu_boundary  in  1  high when core is in fetch1 or halt state (safe hold point)
cpu_hold  out  1  freezes core state register and skip/PC updates
ext_req  in  1  external access request, held until ext_ack
ext_write  in  1  1 = write, 0 = read
ext_addr  in  16  external address
ext_wdata  in  8  external write data
ext_ack  out  1  one-cycle pulse: access done
ext_rdata  out  8  read data, valid with ext_ack
mem_enable  out  1  to memory
mem_write  out  1  to memory
mem_addr  out  16  to memory
mem_wdata  out  8  to memory
mem_rdata  in  8  from memory (combinational)

Behaviour:
- Reset (async, reset_n low): state CPU, cpu_hold=0, ext_ack=0, ext_rdata=8'h00, burst count=0. Memory outputs follow the CPU mux, which is gated off, so mem_enable=0 during reset.
- State machine, registered:
  - CPU: mux selects CPU signals. If ext_req=1 -> DRAIN.
  - DRAIN: mux still selects CPU. cpu_hold is asserted combinationally in DRAIN only when cpu_boundary=1; core freezes from that edge. If cpu_boundary=1 -> EXT. If ext_req drops -> CPU.
  - EXT: cpu_hold=1; mux selects ext signals.
    - Each cycle with ext_req=1 performs one access.
    - Next edge: ext_ack=1, ext_rdata<=mem_rdata (reads; 00 for writes), burst count+1 -> ACK.
  - ACK: cpu_hold=1, mem_enable=0. Requester sees ext_ack and must drop or change its request.
    - If ext_req=1 and count<MAX_BURST -> EXT.
    - Otherwise -> RELEASE.
  - RELEASE: cpu_hold=0, count<=0, mux selects CPU -> CPU. The CPU then runs at least until its next cpu_boundary before DRAIN can re-hold it, which guarantees forward progress.
- Latency: request to first ack is min 3 cycles (CPU, DRAIN at boundary, EXT). Throughput is 1 access per 2 cycles.
- ext_req dropping while in EXT: no access (mem_enable=0) -> RELEASE.
- CPU in halt: cpu_boundary=1, so grant is immediate. Wake during hold is ignored by the core because it is frozen.
- Mux selecting CPU: mem_* = cpu_*.
- Mux selecting ext: mem_enable=ext_req, mem_write=ext_write, mem_addr=ext_addr, mem_wdata=ext_wdata.
- Count width: 8 bits; saturates at MAX_BURST, never wraps.
- Reset mid-burst: the write in flight is discarded unless the clock edge already occurred; no ack is issued.

Optional Feature:
Macro K12A_MEM_ARB_PROTECT_EN.
- Defined: an ext write with ext_addr >= PROTECT_BASE forces mem_enable=0.
  - Still acknowledged normally, with extra output ext_err=1 pulsed alongside ext_ack.
  - ext_err resets to 0.
  - Reads are unaffected.
- Undefined: ext_err port absent; all ext writes reach memory.

Decomposition:
- Shared package k12a.inc.sv gains arb_state_t (ARB_STATE_CPU, ARB_STATE_DRAIN, ARB_STATE_EXT, ARB_STATE_ACK, ARB_STATE_RELEASE).
- Optional sub-module k12a_mem_arbiter_mux: pure combinational source select driving mem_*. Everything else stays in one module.

Test Plan:
1. ext_req read 0x1234 (mem holds 0x5A) while CPU mid-exec -> hold only after cpu_boundary; ext_ack with ext_rdata=0x5A; CPU PC unchanged across hold.
2. Burst of 10 back-to-back ext writes 0x0000..0x0009, MAX_BURST=8 -> 8 acks, RELEASE, CPU executes one instruction, DRAIN, 2 more acks.
3. CPU halted, ext_req write 0x20 to 0x0100 -> ack after 3 cycles; memory[0x0100]=0x20; core stays halted.
4. ext_req asserted then dropped in DRAIN before boundary -> no hold, no ack, state returns to CPU.
5. reset_n low during EXT -> cpu_hold=0, ext_ack=0 immediately; no spurious write after release.
6. With K12A_MEM_ARB_PROTECT_EN: ext write 0xFF to 0xF010 -> ext_ack=1, ext_err=1, memory unchanged; write to 0xEFFF succeeds with ext_err=0.
